mvm_noc_top: RTL and testbench
==============================

Name: mvm_noc_top

Overview:
Multi-tile matrix-vector-multiply (MVM) cluster with one AXI-Stream slave and one AXI-Stream master. Incoming beats are steered by tdest to one of NUM_MVMS tiles and carry one of three payloads: weight rows, instructions or input vectors. Each tile holds per-row weight register files, an instruction memory and accumulators. Results go to the external master port or are forwarded internally as the input vector of another tile, so MLP layers chain.

Parameters:
DATAW, 512, stream data width; vector of LANES=DATAW/EW signed elements.
EW, 8, element width, signed two's complement.
ROWS, 64, dot-product rows per tile; USERW must equal 11+ROWS.
IDW, 32, tid width.
DESTW, 12, tdest width.
USERW, 75, tuser width.
NUM_MVMS, 2, tile count; tile ids 1..NUM_MVMS.
RF_DEPTH, 512, weight RF entries per row (9-bit address).
ACC_DEPTH, 512, accumulator entries (9-bit address).
INST_DEPTH, 64, instruction memory entries per tile.

Ports:
clk  in  1  Clock. All logic is on clk.
rst_n  in  1  Reset. Synchronous, active-low.
clk_noc  in  1  Fabric clock. Must be the same clock as clk; unused internally.
axis_s_tvalid/tready/tlast  in/out/in  1 each  Slave handshake.
axis_s_tdata  in  DATAW  Slave payload.
axis_s_tid  in  IDW  Ignored.
axis_s_tdest  in  DESTW  Target tile id.
axis_s_tuser  in  USERW  [8:0] rf_addr, [10:9] op, [USERW-1:11] one-hot row select.
axis_m_tvalid/tready/tlast  out/in/out  1 each  Master handshake.
axis_m_tdata  out  DATAW  Result vector.
axis_m_tid  out  IDW  Always 0.
axis_m_tdest  out  DESTW  Id of the producing tile.
axis_m_tuser  out  USERW  Always 0.

Behaviour:
- Reset: axis_m_tvalid=0, axis_m_tdata/tid/tdest/tuser/tlast=0. All instruction pointers and write pointers clear. Accumulators clear. RF contents are undefined and are not reset.
- A slave beat is accepted when tvalid&&tready. tlast is ignored; every beat is self-contained.
- axis_s_tready = !(axis_m_tvalid && !axis_m_tready) && !fwd_pending.
- tdest of 0 or greater than NUM_MVMS: the beat is accepted and dropped.
- op=2'b11, weight write: for every row r with tuser[11+r]=1, RF_r[rf_addr] <= tdata. Multiple set bits write multiple rows. All-zero select writes nothing.
- op=2'b00, instruction write: imem[wptr] <= tdata[31:0] and wptr increments, wrapping at INST_DEPTH.
  - Fields: [0] rdc (reserved, stored, ignored); [1] acc_en; [2] rls; [3] lst; [12:4] acc_addr; [21:13] rf_addr; [30:22] rls_dest; [31] rls_op (reserved).
- op=2'b10, input vector: the tile executes imem[iptr] with the vector.
  - For each row r: dot_r = sum over lanes of in[l]*RF_r[rf_addr][l], as a 32-bit signed value.
  - acc[acc_addr][r] <= (acc_en ? acc[acc_addr][r] : 0) + dot_r.
  - iptr increments. If lst=1, iptr wraps to 0 instead.
  - If iptr==wptr (no instruction pending), the vector is dropped and there are no side effects.
- op=2'b01: the beat is accepted and dropped.
- Release: when rls=1, the new accumulator values form the output vector.
  - Row r occupies bits [r*EW +: EW], reduced to EW bits as set by the optional feature.
  - Output appears 2 cycles after the input beat is accepted.
  - rls_dest=0: drive the master port with tlast=1 and tdest equal to the producing tile id.
  - Master tvalid holds, with data stable, until tready.
  - rls_dest in 1..NUM_MVMS: the vector is re-injected as an op=10 input to that tile, and fwd_pending=1 for one cycle. Forwarded vectors take priority over the slave port.
  - Any other rls_dest: the vector is discarded.
- Ordering: beats to one tile are processed in acceptance order. Tiles are independent.
- Reset asserted mid-operation aborts any pending output or forward.

Optional Feature:
MVM_SATURATE_EN
- Defined: each released row value saturates to the signed EW-bit range, -128..127 for EW=8.
- Undefined: each released row value is truncated to its low EW bits.

Test Plan:
- Weight write then compute:
  - Stimulus: tile1, rows 0 and 1, rf_addr=0, all lanes 0x01. Instruction rls=1, rls_dest=0, acc_en=0, rf_addr=0, acc_addr=0. Input all lanes 0x01.
  - Required: one master beat, tdest=1, bytes 0 and 1 = 0x40, other bytes 0x00.
- Saturation:
  - Stimulus: same setup with input all lanes 0x02.
  - Required: byte0=0x7F with MVM_SATURATE_EN defined; byte0=0x80 without it.
- Accumulate:
  - Stimulus: tile1, two instructions at acc_addr=3. First acc_en=0, rls=0; second acc_en=1, rls=1, lst=1. Input all lanes 1 with only lane0 of the weight =5, applied twice.
  - Required: one output, byte0=0x0A. A third input re-runs the first instruction (iptr wrapped).
- Chaining:
  - Stimulus: tile1 instruction rls_dest=2; tile2 instruction rls_dest=0, with an identity weight in row0 (lane0=1).
  - Required: one master beat with tdest=2 and byte0 equal to tile1's row0 result.
- Backpressure:
  - Stimulus: axis_m_tready=0 when the output is produced.
  - Required: axis_m_tvalid stays 1, data is stable, and axis_s_tready=0 until tready=1. The beat transfers exactly once.
- Invalid cases:
  - Stimulus: tdest=5; separately, input to a tile with an empty instruction memory.
  - Required: both beats are accepted, no output, state unchanged.

Source files
------------

// File: rtl/mvm_noc_top.sv
// Multi-tile matrix-vector-multiply cluster behind one AXI-Stream slave and one master.
// Optional MVM_SATURATE_EN: released rows saturate to the signed EW range instead of truncating.
module mvm_noc_top #(
  parameter int DATAW      = 512,
  parameter int EW         = 8,
  parameter int ROWS       = 64,
  parameter int IDW        = 32,
  parameter int DESTW      = 12,
  parameter int USERW      = 75,
  parameter int NUM_MVMS   = 2,
  parameter int RF_DEPTH   = 512,
  parameter int ACC_DEPTH  = 512,
  parameter int INST_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_noc,
  input  logic             axis_s_tvalid,
  output logic             axis_s_tready,
  input  logic             axis_s_tlast,
  input  logic [DATAW-1:0] axis_s_tdata,
  input  logic [IDW-1:0]   axis_s_tid,
  input  logic [DESTW-1:0] axis_s_tdest,
  input  logic [USERW-1:0] axis_s_tuser,
  output logic             axis_m_tvalid,
  input  logic             axis_m_tready,
  output logic             axis_m_tlast,
  output logic [DATAW-1:0] axis_m_tdata,
  output logic [IDW-1:0]   axis_m_tid,
  output logic [DESTW-1:0] axis_m_tdest,
  output logic [USERW-1:0] axis_m_tuser
);

  localparam int LANES = DATAW / EW;
  localparam int TW    = (NUM_MVMS > 1) ? $clog2(NUM_MVMS) : 1;
  localparam int IPW   = $clog2(INST_DEPTH);

  typedef struct packed {
    logic       rls_op;
    logic [8:0] rls_dest;
    logic [8:0] rf_addr;
    logic [8:0] acc_addr;
    logic       lst;
    logic       rls;
    logic       acc_en;
    logic       rdc;
  } inst_t;

  logic [31:0]                  imem    [NUM_MVMS][INST_DEPTH];
  logic [ROWS-1:0][31:0]        acc_mem [NUM_MVMS][ACC_DEPTH];

  logic [NUM_MVMS-1:0][IPW-1:0]       wptr_q, wptr_d, iptr_q, iptr_d;
  logic [NUM_MVMS-1:0][ACC_DEPTH-1:0] acc_vld_q, acc_vld_d;

  logic             s1_valid_q, s1_valid_d;
  logic [TW-1:0]    s1_tile_q, s1_tile_d;
  logic [DATAW-1:0] s1_vec_q, s1_vec_d;
  inst_t            s1_inst_q, s1_inst_d;

  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATAW-1:0] m_data_q, m_data_d;
  logic [DESTW-1:0] m_dest_q, m_dest_d;

  logic             fwd_valid_q, fwd_valid_d;
  logic [TW-1:0]    fwd_tile_q, fwd_tile_d;
  logic [DATAW-1:0] fwd_data_q, fwd_data_d;

  logic             stall, s2_fire;
  logic             in_valid, in_hit;
  logic [TW-1:0]    in_tile;
  logic [1:0]       in_op;
  logic [ROWS-1:0]  in_sel;
  logic [8:0]       in_addr;
  logic [DATAW-1:0] in_data;
  inst_t            cur_inst;
  logic             do_wt, do_iw, do_vec;

  logic [ROWS-1:0][31:0] acc_cur, new_acc;
  logic [DATAW-1:0]      rel_vec;
  logic                  acc_keep;
  logic                  unused_inputs;

  function automatic logic [EW-1:0] reduce(input logic signed [31:0] v);
`ifdef MVM_SATURATE_EN
    logic signed [31:0] sat_max, sat_min;
    sat_max = 32'sd2 ** (EW - 1) - 32'sd1;
    sat_min = -(32'sd2 ** (EW - 1));
    if (v > sat_max) return sat_max[EW-1:0];
    if (v < sat_min) return sat_min[EW-1:0];
    return v[EW-1:0];
`else
    return v[EW-1:0];
`endif
  endfunction

  assign stall         = m_valid_q && !axis_m_tready;
  assign axis_s_tready = !stall && !fwd_valid_q;
  assign s2_fire       = s1_valid_q && !stall;

  // A pending forwarded vector owns the ingress slot; the slave waits.
  always_comb begin
    in_valid = 1'b0;
    in_hit   = 1'b0;
    in_tile  = '0;
    in_op    = '0;
    in_sel   = '0;
    in_addr  = '0;
    in_data  = '0;
    if (!stall) begin
      if (fwd_valid_q) begin
        in_valid = 1'b1;
        in_hit   = 1'b1;
        in_tile  = fwd_tile_q;
        in_op    = 2'b10;
        in_data  = fwd_data_q;
      end else if (axis_s_tvalid) begin
        in_valid = 1'b1;
        in_hit   = (axis_s_tdest != '0) && (axis_s_tdest <= DESTW'(NUM_MVMS));
        in_tile  = in_hit ? TW'(axis_s_tdest - DESTW'(1)) : '0;
        in_op    = axis_s_tuser[10:9];
        in_sel   = axis_s_tuser[USERW-1:11];
        in_addr  = axis_s_tuser[8:0];
        in_data  = axis_s_tdata;
      end
    end
  end

  assign cur_inst = imem[in_tile][iptr_q[in_tile]];
  assign do_wt    = in_valid && in_hit && (in_op == 2'b11);
  assign do_iw    = in_valid && in_hit && (in_op == 2'b00);
  assign do_vec   = in_valid && in_hit && (in_op == 2'b10) &&
                    (iptr_q[in_tile] != wptr_q[in_tile]);

  always_comb begin
    wptr_d     = wptr_q;
    iptr_d     = iptr_q;
    s1_valid_d = s1_valid_q;
    s1_tile_d  = s1_tile_q;
    s1_vec_d   = s1_vec_q;
    s1_inst_d  = s1_inst_q;
    if (do_iw) wptr_d[in_tile] = wptr_q[in_tile] + IPW'(1);
    if (do_vec) iptr_d[in_tile] = cur_inst.lst ? '0 : iptr_q[in_tile] + IPW'(1);
    if (!stall) begin
      s1_valid_d = do_vec;
      s1_tile_d  = in_tile;
      s1_vec_d   = in_data;
      s1_inst_d  = cur_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_iw) imem[in_tile][wptr_q[in_tile]] <= in_data[31:0];
    if (s2_fire) acc_mem[s1_tile_q][s1_inst_q.acc_addr] <= new_acc;
  end

  // Accumulator contents are cleared logically through per-entry valid bits.
  assign acc_cur  = acc_mem[s1_tile_q][s1_inst_q.acc_addr];
  assign acc_keep = s1_inst_q.acc_en && acc_vld_q[s1_tile_q][s1_inst_q.acc_addr];

  always_comb begin
    acc_vld_d = acc_vld_q;
    if (s2_fire) acc_vld_d[s1_tile_q][s1_inst_q.acc_addr] = 1'b1;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATAW-1:0]   rf_mem [NUM_MVMS][RF_DEPTH];
    logic [DATAW-1:0]   rf_word;
    logic signed [31:0] dot;

    always_ff @(posedge clk) begin
      if (rst_n && do_wt && in_sel[r]) rf_mem[in_tile][in_addr] <= in_data;
    end

    assign rf_word = rf_mem[s1_tile_q][s1_inst_q.rf_addr];

    always_comb begin
      dot = '0;
      for (int l = 0; l < LANES; l++) begin
        dot = dot + 32'(signed'(s1_vec_q[l*EW +: EW])) * 32'(signed'(rf_word[l*EW +: EW]));
      end
    end

    assign new_acc[r]            = (acc_keep ? acc_cur[r] : 32'd0) + dot;
    assign rel_vec[r*EW +: EW]   = reduce(new_acc[r]);
  end

  if (DATAW > ROWS * EW) begin : g_pad
    assign rel_vec[DATAW-1:ROWS*EW] = '0;
  end

  // Release routing: external master, forward to a sibling tile, or discard.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_dest_d    = m_dest_q;
    m_last_d    = m_last_q;
    fwd_valid_d = fwd_valid_q && stall;
    fwd_tile_d  = fwd_tile_q;
    fwd_data_d  = fwd_data_q;
    if (m_valid_q && axis_m_tready) m_valid_d = 1'b0;
    if (s2_fire && s1_inst_q.rls) begin
      if (s1_inst_q.rls_dest == '0) begin
        m_valid_d = 1'b1;
        m_data_d  = rel_vec;
        m_dest_d  = DESTW'(s1_tile_q) + DESTW'(1);
        m_last_d  = 1'b1;
      end else if (s1_inst_q.rls_dest <= 9'(NUM_MVMS)) begin
        fwd_valid_d = 1'b1;
        fwd_tile_d  = TW'(s1_inst_q.rls_dest - 9'd1);
        fwd_data_d  = rel_vec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      iptr_q      <= '0;
      acc_vld_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_tile_q   <= '0;
      s1_vec_q    <= '0;
      s1_inst_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_dest_q    <= '0;
      m_last_q    <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_tile_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      iptr_q      <= iptr_d;
      acc_vld_q   <= acc_vld_d;
      s1_valid_q  <= s1_valid_d;
      s1_tile_q   <= s1_tile_d;
      s1_vec_q    <= s1_vec_d;
      s1_inst_q   <= s1_inst_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_dest_q    <= m_dest_d;
      m_last_q    <= m_last_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_tile_q  <= fwd_tile_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign axis_m_tvalid = m_valid_q;
  assign axis_m_tdata  = m_data_q;
  assign axis_m_tdest  = m_dest_q;
  assign axis_m_tlast  = m_last_q;
  assign axis_m_tid    = '0;
  assign axis_m_tuser  = '0;

  assign unused_inputs = ^{clk_noc, axis_s_tlast, axis_s_tid, s1_inst_q.rdc, s1_inst_q.rls_op};

endmodule

// File: tb/tb_mvm_noc_top.sv
// Directed self-checking bench for mvm_noc_top: compute, saturation, accumulate,
// chaining, backpressure and dropped-beat cases.
module tb_mvm_noc_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         axis_s_tvalid, axis_s_tready, axis_s_tlast;
  logic [511:0] axis_s_tdata;
  logic [31:0]  axis_s_tid;
  logic [11:0]  axis_s_tdest;
  logic [74:0]  axis_s_tuser;
  logic         axis_m_tvalid, axis_m_tready, axis_m_tlast;
  logic [511:0] axis_m_tdata;
  logic [31:0]  axis_m_tid;
  logic [11:0]  axis_m_tdest;
  logic [74:0]  axis_m_tuser;

  int compare_count = 0;
  int fail_count    = 0;
  int beat_count    = 0;
  logic [511:0] last_data = '0;
  logic [11:0]  last_dest = '0;
  logic         last_last = 1'b0;

  always #5 clk = ~clk;

  mvm_noc_top dut (
    .clk(clk), .rst_n(rst_n), .clk_noc(clk),
    .axis_s_tvalid(axis_s_tvalid), .axis_s_tready(axis_s_tready), .axis_s_tlast(axis_s_tlast),
    .axis_s_tdata(axis_s_tdata), .axis_s_tid(axis_s_tid), .axis_s_tdest(axis_s_tdest),
    .axis_s_tuser(axis_s_tuser),
    .axis_m_tvalid(axis_m_tvalid), .axis_m_tready(axis_m_tready), .axis_m_tlast(axis_m_tlast),
    .axis_m_tdata(axis_m_tdata), .axis_m_tid(axis_m_tid), .axis_m_tdest(axis_m_tdest),
    .axis_m_tuser(axis_m_tuser)
  );

  // Record every master handshake so the directed steps can count transfers.
  always @(posedge clk) begin
    if (rst_n && axis_m_tvalid && axis_m_tready) begin
      beat_count = beat_count + 1;
      last_data  = axis_m_tdata;
      last_dest  = axis_m_tdest;
      last_last  = axis_m_tlast;
    end
  end

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic acc_en, input logic rls, input logic lst,
                                          input logic [8:0] acc_addr, input logic [8:0] rf_addr,
                                          input logic [8:0] rls_dest);
    return {1'b0, rls_dest, rf_addr, acc_addr, lst, rls, acc_en, 1'b0};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic apply_stimulus(input logic [11:0] dest, input logic [1:0] op, input logic [63:0] sel,
                                input logic [8:0] addr, input logic [511:0] data);
    int waited = 0;
    axis_s_tvalid = 1'b1;
    axis_s_tdest  = dest;
    axis_s_tuser  = {sel, op, addr};
    axis_s_tdata  = data;
    #1;
    while (!axis_s_tready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check_output("beat_accepted", axis_s_tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    axis_s_tvalid = 1'b0;
  endtask

  task automatic send_weight(input logic [11:0] t, input logic [63:0] sel, input logic [8:0] a, input logic [511:0] d);
    apply_stimulus(t, 2'b11, sel, a, d);
  endtask

  task automatic send_inst(input logic [11:0] t, input logic [31:0] inst);
    apply_stimulus(t, 2'b00, 64'd0, 9'd0, {480'd0, inst});
  endtask

  task automatic send_vec(input logic [11:0] t, input logic [511:0] d);
    apply_stimulus(t, 2'b10, 64'd0, 9'd0, d);
  endtask

  task automatic wait_beat(input string tag, input int prev);
    int n = 0;
    while (beat_count == prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_count"}, beat_count, prev + 1);
  endtask

  logic [511:0] ones, twos, exp_v;
  logic [7:0]   sat_byte;
  int           prev;

  initial begin
    ones = {64{8'h01}};
    twos = {64{8'h02}};
`ifdef MVM_SATURATE_EN
    sat_byte = 8'h7F;
`else
    sat_byte = 8'h80;
`endif
    rst_n = 1'b0;
    axis_s_tvalid = 1'b0; axis_s_tlast = 1'b1; axis_s_tid = '0;
    axis_s_tdest = '0; axis_s_tuser = '0; axis_s_tdata = '0;
    axis_m_tready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_m_tvalid", axis_m_tvalid, 1'b0);
    check_output("rst_m_tdata", axis_m_tdata, 512'd0);
    check_output("rst_m_tdest", axis_m_tdest, 12'd0);
    check_output("rst_m_tlast", axis_m_tlast, 1'b0);
    check_output("rst_m_tuser", axis_m_tuser, 75'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_s_tready", axis_s_tready, 1'b1);

    $display("[TB] dropped beats");
    prev = beat_count;
    send_vec(12'd5, ones);
    send_vec(12'd0, ones);
    apply_stimulus(12'd1, 2'b01, 64'd0, 9'd0, ones);
    send_vec(12'd1, ones);
    send_vec(12'd2, ones);
    repeat (5) @(negedge clk);
    check_output("drop_no_output", beat_count, prev);
    check_output("drop_m_tvalid", axis_m_tvalid, 1'b0);

    $display("[TB] weight write then compute");
    send_weight(12'd1, {64{1'b1}}, 9'd0, 512'd0);
    send_weight(12'd1, 64'h3, 9'd0, ones);
    send_inst(12'd1, mk_inst(1'b0, 1'b1, 1'b0, 9'd0, 9'd0, 9'd0));
    exp_v = '0; exp_v[7:0] = 8'h40; exp_v[15:8] = 8'h40;
    prev = beat_count;
    send_vec(12'd1, ones);
    check_output("lat_not_early", axis_m_tvalid, 1'b0);
    @(negedge clk);
    check_output("lat_valid", axis_m_tvalid, 1'b1);
    check_output("t1_tdata", axis_m_tdata, exp_v);
    check_output("t1_tdest", axis_m_tdest, 12'd1);
    check_output("t1_tlast", axis_m_tlast, 1'b1);
    wait_beat("t1", prev);
    check_output("t1_valid_drop", axis_m_tvalid, 1'b0);
    check_output("t1_captured", last_data, exp_v);

    $display("[TB] saturation");
    send_inst(12'd1, mk_inst(1'b0, 1'b1, 1'b0, 9'd0, 9'd0, 9'd0));
    exp_v = '0; exp_v[7:0] = sat_byte; exp_v[15:8] = sat_byte;
    prev = beat_count;
    send_vec(12'd1, twos);
    wait_beat("sat", prev);
    check_output("sat_data", last_data, exp_v);

    $display("[TB] accumulate");
    send_weight(12'd1, {64{1'b1}}, 9'd1, 512'd0);
    send_weight(12'd1, 64'h1, 9'd1, 512'h05);
    send_inst(12'd1, mk_inst(1'b0, 1'b0, 1'b0, 9'd3, 9'd1, 9'd0));
    send_inst(12'd1, mk_inst(1'b1, 1'b1, 1'b1, 9'd3, 9'd1, 9'd0));
    prev = beat_count;
    send_vec(12'd1, ones);
    repeat (4) @(negedge clk);
    check_output("acc_no_release", beat_count, prev);
    send_vec(12'd1, ones);
    wait_beat("acc", prev);
    check_output("acc_data", last_data, 512'h0A);
    prev = beat_count;
    send_vec(12'd1, ones);
    wait_beat("wrap", prev);
    exp_v = '0; exp_v[7:0] = 8'h40; exp_v[15:8] = 8'h40;
    check_output("wrap_data", last_data, exp_v);

    $display("[TB] chaining");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_weight(12'd1, {64{1'b1}}, 9'd0, 512'd0);
    send_weight(12'd1, 64'h3, 9'd0, ones);
    send_weight(12'd2, {64{1'b1}}, 9'd0, 512'd0);
    send_weight(12'd2, 64'h1, 9'd0, 512'h01);
    send_inst(12'd1, mk_inst(1'b0, 1'b1, 1'b1, 9'd0, 9'd0, 9'd2));
    send_inst(12'd2, mk_inst(1'b0, 1'b1, 1'b1, 9'd0, 9'd0, 9'd0));
    prev = beat_count;
    send_vec(12'd1, ones);
    @(negedge clk);
    check_output("fwd_blocks_slave", axis_s_tready, 1'b0);
    check_output("fwd_no_direct", axis_m_tvalid, 1'b0);
    wait_beat("chain", prev);
    check_output("chain_tdest", last_dest, 12'd2);
    check_output("chain_data", last_data, 512'h40);
    repeat (3) @(negedge clk);
    check_output("chain_single_beat", beat_count, prev + 1);

    $display("[TB] backpressure");
    axis_m_tready = 1'b0;
    prev = beat_count;
    send_vec(12'd2, 512'h07);
    repeat (3) @(negedge clk);
    check_output("bp_valid", axis_m_tvalid, 1'b1);
    check_output("bp_data", axis_m_tdata, 512'h07);
    check_output("bp_s_tready", axis_s_tready, 1'b0);
    check_output("bp_no_xfer", beat_count, prev);
    repeat (2) @(negedge clk);
    check_output("bp_valid_hold", axis_m_tvalid, 1'b1);
    check_output("bp_data_stable", axis_m_tdata, 512'h07);
    axis_m_tready = 1'b1;
    @(negedge clk);
    check_output("bp_xfer", beat_count, prev + 1);
    check_output("bp_valid_drop", axis_m_tvalid, 1'b0);
    repeat (3) @(negedge clk);
    check_output("bp_once", beat_count, prev + 1);
    check_output("bp_captured", last_data, 512'h07);
    check_output("bp_tlast", last_last, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
